// File: rtl/wb_pipe_arbiter.sv
// Arbitrates NCH pipelined Wishbone masters onto one slave bus, with fixed-priority or
// round-robin selection, a per-grant outstanding-transfer limit and an ack timeout.
module wb_pipe_arbiter #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MODE    = 0,
  parameter int unsigned MAXOUT  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH-1:0]         m_cyc_i,
  input  logic [NCH-1:0]         m_stb_i,
  input  logic [NCH-1:0]         m_we_i,
  input  logic [NCH*AW-1:0]      m_adr_i,
  input  logic [NCH*(DW/8)-1:0]  m_sel_i,
  input  logic [NCH*DW-1:0]      m_dat_i,
  output logic [DW-1:0]          m_dat_o,
  output logic [NCH-1:0]         m_ack_o,
  output logic [NCH-1:0]         m_err_o,
  output logic [NCH-1:0]         m_stall_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW/8-1:0]        s_sel_o,
  output logic [DW-1:0]          s_dat_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_stall_i,
  output logic [NCH-1:0]         gnt_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned OW = $clog2(MAXOUT + 1);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0] MaxOut     = OW'(MAXOUT);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic           win_valid;
  logic [IW-1:0]  win_idx;
  logic [NCH-1:0] win_oh;
  logic [IW-1:0]  ptr_nxt;

  logic           sel_cyc, sel_stb, sel_we;
  logic [AW-1:0]  sel_adr;
  logic [SW-1:0]  sel_sel;
  logic [DW-1:0]  sel_dat;

  logic in_grant, full, has_out, resp, accept, timeout_hit, stall_g;

  // Round robin: first pass only considers channels at or after the pointer, second wraps.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!win_valid && m_cyc_i[k] && ((MODE == 0) || (k >= int'(ptr_q)))) begin
        win_valid = 1'b1;
        win_idx   = IW'(k);
        win_oh[k] = 1'b1;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (!win_valid && m_cyc_i[k]) begin
        win_valid = 1'b1;
        win_idx   = IW'(k);
        win_oh[k] = 1'b1;
      end
    end
    ptr_nxt = (32'(win_idx) == NCH - 1) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_sel = '0;
    sel_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_q[k]) begin
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_we  = m_we_i[k];
        sel_adr = m_adr_i[k*AW +: AW];
        sel_sel = m_sel_i[k*SW +: SW];
        sel_dat = m_dat_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    in_grant    = (state_q == StGrant);
    full        = (outst_q == MaxOut);
    has_out     = (outst_q != '0);
    // Responses with nothing outstanding, or after the master let go, are dropped.
    resp        = (s_ack_i | s_err_i) & has_out & in_grant & sel_cyc;
    timeout_hit = (TIMEOUT != 0) && in_grant && sel_cyc && has_out &&
                  !(s_ack_i | s_err_i) && (timer_q == TimeoutVal);

    s_cyc_o = in_grant & sel_cyc;
    s_stb_o = in_grant & sel_cyc & sel_stb & ~full;
    s_we_o  = in_grant & sel_we;
    s_adr_o = in_grant ? sel_adr : '0;
    s_sel_o = in_grant ? sel_sel : '0;
    s_dat_o = in_grant ? sel_dat : '0;
    accept  = s_stb_o & ~s_stall_i;

    stall_g   = ~in_grant | s_stall_i | full;
    m_stall_o = ~gnt_q | {NCH{stall_g}};
    m_ack_o   = gnt_q & {NCH{resp & s_ack_i}};
    m_err_o   = gnt_q & {NCH{(resp & s_err_i) | timeout_hit}};
    m_dat_o   = s_dat_i;
    gnt_o     = gnt_q;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    outst_d = outst_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StGrant;
          gnt_d   = win_oh;
          outst_d = '0;
          timer_d = '0;
          if (MODE == 1) ptr_d = ptr_nxt;
        end
      end
      StGrant: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
          outst_d = '0;
          timer_d = '0;
        end else if (timeout_hit) begin
          state_d = StAbort;
          outst_d = '0;
          timer_d = '0;
        end else begin
          if (accept && !resp)      outst_d = outst_q + 1'b1;
          else if (!accept && resp) outst_d = outst_q - 1'b1;
          if (resp || !has_out || (TIMEOUT == 0)) timer_d = '0;
          else                                    timer_d = timer_q + 1'b1;
        end
      end
      StAbort: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      outst_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      outst_q <= outst_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_pipe_arbiter.sv
// Directed bench: instance a is 2-channel fixed priority (MAXOUT 4, TIMEOUT 10),
// instance b is 3-channel round robin.
module tb_wb_pipe_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a
  logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_err, a_stall, a_gnt;
  logic [63:0] a_adr, a_wdat;
  logic [7:0]  a_sel;
  logic [31:0] a_rdat, a_sadr, a_sdat, a_sdin;
  logic [3:0]  a_ssel;
  logic        a_scyc, a_sstb, a_swe, a_sack, a_serr, a_sstall;

  // Instance b
  logic [2:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_stall, b_gnt, b_sel, b_ssel;
  logic [23:0] b_adr, b_wdat;
  logic [7:0]  b_rdat, b_sadr, b_sdat, b_sdin;
  logic        b_scyc, b_sstb, b_swe, b_sack, b_serr, b_sstall;

  wb_pipe_arbiter #(
    .NCH(2), .AW(32), .DW(32), .MODE(0), .MAXOUT(4), .TIMEOUT(10)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_adr_i(a_adr), .m_sel_i(a_sel),
    .m_dat_i(a_wdat), .m_dat_o(a_rdat), .m_ack_o(a_ack), .m_err_o(a_err),
    .m_stall_o(a_stall), .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
    .s_adr_o(a_sadr), .s_sel_o(a_ssel), .s_dat_o(a_sdat), .s_dat_i(a_sdin),
    .s_ack_i(a_sack), .s_err_i(a_serr), .s_stall_i(a_sstall), .gnt_o(a_gnt)
  );

  wb_pipe_arbiter #(
    .NCH(3), .AW(8), .DW(8), .MODE(1), .MAXOUT(2), .TIMEOUT(0)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_adr_i(b_adr), .m_sel_i(b_sel),
    .m_dat_i(b_wdat), .m_dat_o(b_rdat), .m_ack_o(b_ack), .m_err_o(b_err),
    .m_stall_o(b_stall), .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
    .s_adr_o(b_sadr), .s_sel_o(b_ssel), .s_dat_o(b_sdat), .s_dat_i(b_sdin),
    .s_ack_i(b_sack), .s_err_i(b_serr), .s_stall_i(b_sstall), .gnt_o(b_gnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_scyc !== 1'b0) begin bad++; $display("FAIL rst_scyc: got %b want 0", a_scyc); end
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", a_gnt); end
    total++; if (a_stall !== 2'b11) begin bad++; $display("FAIL rst_stall: got %b want 11", a_stall); end
    total++; if (a_sadr !== 32'h0) begin bad++; $display("FAIL rst_sadr: got %h want 0", a_sadr); end
    total++; if (b_stall !== 3'b111) begin bad++; $display("FAIL rst_b_stall: got %b want 111", b_stall); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_fixed_prio();
    a_adr  = {32'h0000_2000, 32'h0000_1000};
    a_wdat = {32'hCAFE_0001, 32'h1234_5678};
    a_sel  = {4'hC, 4'h3};
    a_we   = 2'b10;
    a_cyc  = 2'b11;
    step(); #1;
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL fp_gnt0: got %b want 01", a_gnt); end
    total++; if (a_scyc !== 1'b1) begin bad++; $display("FAIL fp_scyc: got %b want 1", a_scyc); end
    total++; if (a_stall !== 2'b10) begin bad++; $display("FAIL fp_stall: got %b want 10", a_stall); end
    a_stb = 2'b11; #1;
    total++; if (a_sstb !== 1'b1) begin bad++; $display("FAIL fp_sstb: got %b want 1", a_sstb); end
    total++; if (a_sadr !== 32'h1000) begin bad++; $display("FAIL fp_sadr0: got %h want 1000", a_sadr); end
    total++; if (a_ssel !== 4'h3) begin bad++; $display("FAIL fp_ssel0: got %h want 3", a_ssel); end
    total++; if (a_swe !== 1'b0) begin bad++; $display("FAIL fp_swe0: got %b want 0", a_swe); end
    step();
    a_stb = 2'b00; a_sack = 1'b1; a_sdin = 32'hA5A5_0F0F; #1;
    total++; if (a_ack !== 2'b01) begin bad++; $display("FAIL fp_ack: got %b want 01", a_ack); end
    total++; if (a_rdat !== 32'hA5A5_0F0F) begin bad++; $display("FAIL fp_rdat: got %h want a5a50f0f", a_rdat); end
    step();
    a_sack = 1'b0; a_sstall = 1'b1; #1;
    total++; if (a_stall !== 2'b11) begin bad++; $display("FAIL fp_stall_pass: got %b want 11", a_stall); end
    a_sstall = 1'b0; a_cyc = 2'b10; #1;
    total++; if (a_scyc !== 1'b0) begin bad++; $display("FAIL fp_release: got %b want 0", a_scyc); end
    step(); #1;
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL fp_gap_gnt: got %b want 00", a_gnt); end
    total++; if (a_scyc !== 1'b0) begin bad++; $display("FAIL fp_gap_scyc: got %b want 0", a_scyc); end
    step(); #1;
    total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL fp_gnt1: got %b want 10", a_gnt); end
    total++; if (a_sadr !== 32'h2000) begin bad++; $display("FAIL fp_sadr1: got %h want 2000", a_sadr); end
    total++; if (a_sdat !== 32'hCAFE_0001) begin bad++; $display("FAIL fp_sdat1: got %h want cafe0001", a_sdat); end
    total++; if (a_swe !== 1'b1) begin bad++; $display("FAIL fp_swe1: got %b want 1", a_swe); end
    a_sack = 1'b1; #1;
    total++; if (a_ack !== 2'b00) begin bad++; $display("FAIL fp_stray_ack: got %b want 00", a_ack); end
    a_sack = 1'b0; a_cyc = 2'b00;
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt [4];
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
    b_cyc = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (b_gnt !== exp_gnt[i]) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, b_gnt, exp_gnt[i]); end
      b_stb = exp_gnt[i];
      step();
      b_stb = 3'b000; b_sack = 1'b1; #1;
      total++; if (b_ack !== exp_gnt[i]) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", i, b_ack, exp_gnt[i]); end
      step();
      b_sack = 1'b0; b_cyc = 3'b111 & ~exp_gnt[i];
      step(); #1;
      total++; if (b_scyc !== 1'b0) begin bad++; $display("FAIL rr_gap%0d: got %b want 0", i, b_scyc); end
      b_cyc = 3'b111;
      step();
    end
    b_cyc = 3'b000;
    step(); step(); step();
  endtask

  task automatic test_pipeline();
    int   issued;
    int   acks;
    int   other;
    bit   due [40];
    logic acc;
    logic exp_st;
    issued = 0; acks = 0; other = 0;
    for (int i = 0; i < 40; i++) due[i] = 1'b0;
    a_cyc = 2'b01;
    step();
    for (int c = 0; c < 20; c++) begin
      a_stb  = {1'b0, issued < 8};
      a_sack = due[c];
      #1;
      acc = a_stb[0] & ~a_stall[0];
      exp_st = (c >= 4) && (c <= 6);
      if (c <= 10) begin
        total++; if (a_stall[0] !== exp_st) begin bad++; $display("FAIL pl_stall c%0d: got %b want %b", c, a_stall[0], exp_st); end
      end
      if (c == 5) begin
        total++; if (a_sstb !== 1'b0) begin bad++; $display("FAIL pl_sstb_full: got %b want 0", a_sstb); end
        total++; if (issued !== 4) begin bad++; $display("FAIL pl_accepted: got %0d want 4", issued); end
      end
      if (a_ack[0]) acks++;
      if (a_ack[1] || a_err != 2'b00) other++;
      if (acc) begin
        issued++;
        due[c + 6] = 1'b1;
      end
      step();
    end
    a_stb = 2'b00; a_sack = 1'b0;
    total++; if (acks !== 8) begin bad++; $display("FAIL pl_acks: got %0d want 8", acks); end
    total++; if (issued !== 8) begin bad++; $display("FAIL pl_issued: got %0d want 8", issued); end
    total++; if (other !== 0) begin bad++; $display("FAIL pl_stray: got %0d want 0", other); end
    a_cyc = 2'b00;
    step(); step();
  endtask

  task automatic test_err();
    a_cyc = 2'b01;
    step();
    a_stb = 2'b01;
    step();
    a_sack = 1'b1; #1;
    total++; if (a_ack !== 2'b01 || a_err !== 2'b00) begin bad++; $display("FAIL er_beat1: got ack %b err %b want 01 00", a_ack, a_err); end
    step();
    a_sack = 1'b0; a_serr = 1'b1; #1;
    total++; if (a_err !== 2'b01 || a_ack !== 2'b00) begin bad++; $display("FAIL er_beat2: got ack %b err %b want 00 01", a_ack, a_err); end
    step();
    a_stb = 2'b00; a_serr = 1'b0; a_sack = 1'b1; #1;
    total++; if (a_ack !== 2'b01) begin bad++; $display("FAIL er_beat3: got %b want 01", a_ack); end
    total++; if (a_scyc !== 1'b1) begin bad++; $display("FAIL er_cyc: got %b want 1", a_scyc); end
    step(); #1;
    total++; if (a_ack !== 2'b00) begin bad++; $display("FAIL er_drained: got %b want 00", a_ack); end
    a_sack = 1'b0; a_cyc = 2'b00;
    step(); step();
  endtask

  task automatic test_timeout();
    int first_err;
    first_err = -1;
    a_cyc = 2'b01;
    step();
    a_stb = 2'b01;
    step();
    a_stb = 2'b00; #1;
    total++; if (a_err !== 2'b00) begin bad++; $display("FAIL to_early: got %b want 00", a_err); end
    for (int k = 1; k <= 15 && first_err < 0; k++) begin
      step(); #1;
      if (a_err[0]) first_err = k;
    end
    total++; if (first_err !== 10) begin bad++; $display("FAIL to_latency: got %0d want 10", first_err); end
    step(); #1;
    total++; if (a_err !== 2'b00) begin bad++; $display("FAIL to_pulse: got %b want 00", a_err); end
    total++; if (a_scyc !== 1'b0) begin bad++; $display("FAIL to_abort_cyc: got %b want 0", a_scyc); end
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL to_abort_gnt: got %b want 01", a_gnt); end
    a_sack = 1'b1; #1;
    total++; if (a_ack !== 2'b00) begin bad++; $display("FAIL to_late_ack: got %b want 00", a_ack); end
    a_sack = 1'b0;
    step();
    a_cyc = 2'b00;
    step(); #1;
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL to_idle: got %b want 00", a_gnt); end
    step();
  endtask

  task automatic test_reset_mid();
    a_cyc = 2'b01;
    step();
    a_stb = 2'b01;
    step(); step();
    a_stb = 2'b00; #1;
    rst = 1'b0; #1;
    total++; if (a_scyc !== 1'b0) begin bad++; $display("FAIL rm_scyc: got %b want 0", a_scyc); end
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL rm_gnt: got %b want 00", a_gnt); end
    total++; if (a_stall !== 2'b11) begin bad++; $display("FAIL rm_stall: got %b want 11", a_stall); end
    rst = 1'b1;
    step(); #1;
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL rm_regrant: got %b want 01", a_gnt); end
    a_sack = 1'b1; #1;
    total++; if (a_ack !== 2'b00) begin bad++; $display("FAIL rm_cleared: got %b want 00", a_ack); end
    a_sack = 1'b0; a_cyc = 2'b00;
    step(); step();
  endtask

  initial begin
    a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_sel = '0; a_wdat = '0;
    a_sdin = '0; a_sack = 1'b0; a_serr = 1'b0; a_sstall = 1'b0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_sel = '0; b_wdat = '0;
    b_sdin = '0; b_sack = 1'b0; b_serr = 1'b0; b_sstall = 1'b0;
    test_reset();
    test_fixed_prio();
    test_round_robin();
    test_pipeline();
    test_err();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
